lc3_decode: RTL and testbench

Decode stage of the LC3 pipeline, directly downstream of fetch. Each cycle fetch enables it, the stage registers the instruction word returned from instruction memory and the fetch-stage next PC. It then produces the registered instruction, the forwarded NPC and the execute, writeback and memory control words consumed by the execute, writeback and memory-access stages. It is a single-stage register with an opcode-driven control decoder and a hold capability for pipeline stalls.

---
 rtl/lc3_decode_if.sv | 23 ++
 rtl/lc3_decode.sv | 91 +++++++++
 tb/tb_lc3_decode.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_decode_if.sv
// Fetch-to-decode bus: load strobe, instruction word and NPC in, registered
// instruction, NPC and control words out.
interface lc3_decode_if;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        illegal_op;

    modport master (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op
    );

    modport slave (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op
    );
endinterface

// File: rtl/lc3_decode.sv
// LC3 decode stage: registers the fetched instruction and NPC and produces the
// execute/writeback/memory control words, holding everything while stalled.
module lc3_decode (
    input  logic             clock,
    input  logic             reset,
    lc3_decode_if.slave      dec
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned E_W    = 6;
    localparam int unsigned W_W    = 2;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [WORD_W-1:0] ir_q, npc_q;
    logic [E_W-1:0]    e_q, e_d;
    logic [W_W-1:0]    w_q, w_d;
    logic              mem_q, mem_d;
    logic              ill_q, ill_d;

    logic [1:0] alu_ctl;
    logic [1:0] pc_sel1;
    logic       pc_sel2;
    logic       op2_sel;
    logic [3:0] opcode;

    assign opcode = dec.dout[15:12];

    // Opcode decoder; unlisted fields stay zero, unsupported opcodes flag illegal.
    always_comb begin
        alu_ctl = 2'b00;
        pc_sel1 = 2'b00;
        pc_sel2 = 1'b0;
        op2_sel = 1'b0;
        w_d     = 2'b00;
        mem_d   = 1'b0;
        ill_d   = 1'b0;
        case (opcode)
            OP_ADD: begin alu_ctl = 2'b00; op2_sel = dec.dout[5]; end
            OP_AND: begin alu_ctl = 2'b01; op2_sel = dec.dout[5]; end
            OP_NOT: alu_ctl = 2'b10;
            OP_BR:  begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; end
            OP_JMP: pc_sel1 = 2'b11;
            OP_LD:  begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; w_d = 2'b01; end
            OP_LDI: begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; w_d = 2'b01; mem_d = 1'b1; end
            OP_LDR: begin pc_sel1 = 2'b10; w_d = 2'b01; end
            OP_LEA: begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; w_d = 2'b10; end
            OP_ST:  begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; end
            OP_STI: begin pc_sel1 = 2'b01; pc_sel2 = 1'b1; mem_d = 1'b1; end
            OP_STR: pc_sel1 = 2'b10;
            default: ill_d = 1'b1;
        endcase
        e_d = {alu_ctl, pc_sel1, pc_sel2, op2_sel};
    end

    // Load/hold register; reset discards any held instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            w_q   <= '0;
            mem_q <= 1'b0;
            ill_q <= 1'b0;
        end else if (dec.enable_decode) begin
            ir_q  <= dec.dout;
            npc_q <= dec.npc_in;
            e_q   <= e_d;
            w_q   <= w_d;
            mem_q <= mem_d;
            ill_q <= ill_d;
        end
    end

    assign dec.IR          = ir_q;
    assign dec.npc_out     = npc_q;
    assign dec.E_Control   = e_q;
    assign dec.W_Control   = w_q;
    assign dec.Mem_Control = mem_q;
    assign dec.illegal_op  = ill_q;
endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: expected output words are queued as
// stimulus is driven and compared one cycle later.
module tb_lc3_decode;
    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        mem;
        logic        ill;
    } out_t;

    logic clock;
    logic reset;
    lc3_decode_if bus ();

    lc3_decode dut (
        .clock (clock),
        .reset (reset),
        .dec   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    out_t sb[$];
    out_t held;
    int   passed;
    int   total;

    function automatic out_t observed();
        out_t o;
        o.ir  = bus.IR;
        o.npc = bus.npc_out;
        o.e   = bus.E_Control;
        o.w   = bus.W_Control;
        o.mem = bus.Mem_Control;
        o.ill = bus.illegal_op;
        return o;
    endfunction

    // Reference decoder written from the opcode table.
    function automatic out_t model(input logic [15:0] d, input logic [15:0] n);
        out_t o;
        o = '0;
        o.ir  = d;
        o.npc = n;
        case (d[15:12])
            4'h1: o.e = {5'b00000, d[5]};
            4'h5: o.e = {5'b01000, d[5]};
            4'h9: o.e = 6'b100000;
            4'h0: o.e = 6'b000110;
            4'hC: o.e = 6'b001100;
            4'h2: begin o.e = 6'b000110; o.w = 2'b01; end
            4'hA: begin o.e = 6'b000110; o.w = 2'b01; o.mem = 1'b1; end
            4'h6: begin o.e = 6'b001000; o.w = 2'b01; end
            4'hE: begin o.e = 6'b000110; o.w = 2'b10; end
            4'h3: o.e = 6'b000110;
            4'hB: begin o.e = 6'b000110; o.mem = 1'b1; end
            4'h7: o.e = 6'b001000;
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

    function automatic out_t mk(input logic [15:0] ir, input logic [15:0] npc,
                                input logic [5:0] e, input logic [1:0] w,
                                input logic mem, input logic ill);
        out_t o;
        o.ir = ir; o.npc = npc; o.e = e; o.w = w; o.mem = mem; o.ill = ill;
        return o;
    endfunction

    task automatic drive(input logic en, input logic [15:0] d, input logic [15:0] n);
        @(negedge clock);
        bus.enable_decode = en;
        bus.dout          = d;
        bus.npc_in        = n;
    endtask

    task automatic test_reset();
        out_t got, exp;
        reset = 1'b1;
        drive(1'b1, 16'h1021, 16'h3001);
        sb.push_back(mk(16'h0, 16'h0, 6'h0, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        bus.enable_decode = 1'b0;
        held = '0;
    endtask

    task automatic test_add_imm();
        out_t got, exp;
        drive(1'b1, 16'h1021, 16'h3001);
        sb.push_back(mk(16'h1021, 16'h3001, 6'h01, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL add_imm got=%h exp=%h", got, exp);
        else passed++;
        held = exp;
    endtask

    task automatic test_back_to_back();
        out_t got, exp;
        logic [15:0] ins [2];
        logic [5:0]  ev  [2];
        ins[0] = 16'h5042; ev[0] = 6'h10;
        ins[1] = 16'h903F; ev[1] = 6'h20;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ins[i], 16'h3002 + 16'(i));
            sb.push_back(mk(ins[i], 16'h3002 + 16'(i), ev[i], 2'b00, 1'b0, 1'b0));
            @(posedge clock); #1;
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
            held = exp;
        end
    endtask

    task automatic test_loads();
        out_t got, exp;
        out_t tab [3];
        tab[0] = mk(16'hA205, 16'h4000, 6'h06, 2'b01, 1'b1, 1'b0);
        tab[1] = mk(16'h6283, 16'h4001, 6'h08, 2'b01, 1'b0, 1'b0);
        tab[2] = mk(16'hE1FF, 16'h4002, 6'h06, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, tab[i].ir, tab[i].npc);
            sb.push_back(tab[i]);
            @(posedge clock); #1;
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL loads[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
            held = exp;
        end
    endtask

    task automatic test_stall();
        out_t got, exp, jmp;
        jmp = mk(16'hC1C0, 16'h5000, 6'h0C, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'hC1C0, 16'h5000);
        sb.push_back(jmp);
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL stall_capture got=%h exp=%h", got, exp);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h1021, 16'h6000 + 16'(i * 7));
            sb.push_back(jmp);
            @(posedge clock); #1;
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
        end
        drive(1'b1, 16'h1021, 16'h6100);
        sb.push_back(mk(16'h1021, 16'h6100, 6'h01, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL stall_release got=%h exp=%h", got, exp);
        else passed++;
        held = exp;
    endtask

    task automatic test_illegal();
        out_t got, exp;
        logic [15:0] ops [5];
        ops[0] = 16'hF025; ops[1] = 16'h1021; ops[2] = 16'h4ABC;
        ops[3] = 16'h8000; ops[4] = 16'hD123;
        sb.push_back(mk(16'hF025, 16'hFFFF, 6'h00, 2'b00, 1'b0, 1'b1));
        sb.push_back(mk(16'h1021, 16'h0000, 6'h01, 2'b00, 1'b0, 1'b0));
        sb.push_back(mk(16'h4ABC, 16'h0001, 6'h00, 2'b00, 1'b0, 1'b1));
        sb.push_back(mk(16'h8000, 16'h0002, 6'h00, 2'b00, 1'b0, 1'b1));
        sb.push_back(mk(16'hD123, 16'h0003, 6'h00, 2'b00, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], (i == 0) ? 16'hFFFF : 16'(i - 1));
            @(posedge clock); #1;
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL illegal[%0d] got=%h exp=%h", i, got, exp);
            else passed++;
            held = exp;
        end
    endtask

    task automatic test_async_reset();
        out_t got, exp, zero;
        zero = '0;
        drive(1'b1, 16'hB001, 16'h7000);
        sb.push_back(mk(16'hB001, 16'h7000, 6'h06, 2'b00, 1'b1, 1'b0));
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL sti_capture got=%h exp=%h", got, exp);
        else passed++;
        // Mid-cycle reset while holding the STI.
        bus.enable_decode = 1'b0;
        #2;
        reset = 1'b1;
        sb.push_back(zero);
        #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL async_reset got=%h exp=%h", got, exp);
        else passed++;
        drive(1'b1, 16'h1021, 16'h7001);
        sb.push_back(zero);
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL reset_blocks_load got=%h exp=%h", got, exp);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        bus.enable_decode = 1'b0;
        sb.push_back(zero);
        @(posedge clock); #1;
        exp = sb.pop_front(); got = observed(); total++;
        if (got !== exp) $display("FAIL no_replay got=%h exp=%h", got, exp);
        else passed++;
        held = zero;
    endtask

    task automatic test_random();
        out_t got, exp;
        logic [15:0] d, n;
        logic en;
        for (int i = 0; i < 60; i++) begin
            d  = 16'($urandom);
            n  = 16'($urandom);
            en = ($urandom_range(0, 3) != 0);
            drive(en, d, n);
            if (en) held = model(d, n);
            sb.push_back(held);
            @(posedge clock); #1;
            exp = sb.pop_front(); got = observed(); total++;
            if (got !== exp) $display("FAIL random[%0d] d=%h en=%b got=%h exp=%h", i, d, en, got, exp);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        bus.enable_decode = 1'b0;
        bus.dout   = '0;
        bus.npc_in = '0;
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_loads();
        test_stall();
        test_illegal();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
